poly_tone_bank: RTL

POLY_TONE_BANK -- requirements
Module: poly_tone_bank

---
 rtl/tone_pkg.sv | 13 +
 rtl/tone_voice.sv | 97 +++++++++
 rtl/poly_tone_bank.sv | 70 +++++++
 3 files changed

// File: rtl/tone_pkg.sv
// Shared constants for the polyphonic tone bank.
// Half-periods are in 50 MHz clock cycles for C4..C5.
package tone_pkg;

  localparam int OCT_W     = 2;
  localparam int NUM_NOTES = 8;

  localparam int unsigned BASE_HALF [NUM_NOTES] = '{
    95556, 85131, 75843, 71586,
    63776, 56818, 50619, 47778
  };

endpackage

// File: rtl/tone_voice.sv
// One tone voice: key synchronizer, debounce,
// octave-scaled divider, phase and speaker register.
module tone_voice
  import tone_pkg::*;
#(
  parameter int          DIV_W      = 17,
  parameter int          DEB_CYCLES = 250000,
  parameter int unsigned BASE       = 95556
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_key,
  input  logic [OCT_W-1:0] i_octave,
  input  logic             i_mute,
  output logic             o_active,
  output logic             o_speaker
);

  localparam int DEB_W = $clog2(DEB_CYCLES + 1);
  localparam logic [DEB_W-1:0] DEB_LAST =
    DEB_W'(DEB_CYCLES - 1);
  localparam logic [DIV_W-1:0] BASE_V = DIV_W'(BASE);

  logic [1:0]       r_sync;
  logic [DEB_W-1:0] r_deb;
  logic             r_active;
  logic [DIV_W-1:0] r_cnt;
  logic [DIV_W-1:0] r_half;
  logic             r_phase;
  logic             r_spk;

  logic             w_key_s;
  logic [DIV_W-1:0] w_shift;
  logic [DIV_W-1:0] w_half;
  logic             w_wrap;

  assign w_key_s = r_sync[1];
  assign w_shift = BASE_V >> i_octave;
  assign w_half  = (w_shift == '0) ? DIV_W'(1) : w_shift;
  assign w_wrap  = (r_cnt == r_half - DIV_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[0], i_key};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_deb    <= '0;
      r_active <= 1'b0;
    end else if (w_key_s != r_active) begin
      if (r_deb == DEB_LAST) begin
        r_deb    <= '0;
        r_active <= w_key_s;
      end else begin
        r_deb <= r_deb + DEB_W'(1);
      end
    end else begin
      r_deb <= '0;
    end
  end

  // Octave is latched into r_half only at note start
  // and at each toggle, so a half-period never changes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_half  <= DIV_W'(1);
      r_phase <= 1'b0;
    end else if (!r_active) begin
      r_cnt   <= '0;
      r_half  <= w_half;
      r_phase <= 1'b0;
    end else if (w_wrap) begin
      r_cnt   <= '0;
      r_half  <= w_half;
      r_phase <= ~r_phase;
    end else begin
      r_cnt <= r_cnt + DIV_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_spk <= 1'b0;
    end else begin
      r_spk <= r_phase & r_active & ~i_mute;
    end
  end

  assign o_active  = r_active;
  assign o_speaker = r_spk;

endmodule

// File: rtl/poly_tone_bank.sv
// Bank of independent square-wave voices with a
// registered popcount mix of the speaker lines.
module poly_tone_bank
  import tone_pkg::*;
#(
  parameter int NUM_VOICES = 8,
  parameter int DIV_W      = 17,
  parameter int DEB_CYCLES = 250000,
  parameter int MIX_W      = $clog2(NUM_VOICES + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_VOICES-1:0] key,
  input  logic [OCT_W-1:0]      octave,
  input  logic                  mute,
  output logic [NUM_VOICES-1:0] speaker,
  output logic [NUM_VOICES-1:0] active,
  output logic [MIX_W-1:0]      mix
);

  logic [1:0]       r_rst;
  logic [MIX_W-1:0] r_mix;
  logic             w_rst_n;
  logic [MIX_W-1:0] w_pop;

  // Assert asynchronously, release on a clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rst <= '0;
    end else begin
      r_rst <= {r_rst[0], 1'b1};
    end
  end

  assign w_rst_n = r_rst[1];

  for (genvar v = 0; v < NUM_VOICES; v++) begin : g_voice
    tone_voice #(
      .DIV_W      (DIV_W),
      .DEB_CYCLES (DEB_CYCLES),
      .BASE       (BASE_HALF[v % NUM_NOTES])
    ) u_voice (
      .clk       (clk),
      .rst_n     (w_rst_n),
      .i_key     (key[v]),
      .i_octave  (octave),
      .i_mute    (mute),
      .o_active  (active[v]),
      .o_speaker (speaker[v])
    );
  end

  always_comb begin
    w_pop = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      w_pop = w_pop + MIX_W'(speaker[i]);
    end
  end

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_mix <= '0;
    end else begin
      r_mix <= w_pop;
    end
  end

  assign mix = r_mix;

endmodule
